// File: rtl/block_fetch_unit.sv
// ---------------------------------------------------------------------------
// block_fetch_unit
// Instruction fetch front end. Holds the fetch PC, issues one word fetch at a
// time over a valid/ready request channel (valid-only response), buffers the
// returned words in a small FIFO and presents the head entry downstream as
// the full word, its PC and the decoded op/funct3/funct7 fields. A redirect
// flushes the FIFO and discards any in-flight response.
//
// Ports:
//   i_clk             clock, rising edge
//   i_rst_n           synchronous active-low reset
//   o_imem_req_valid  fetch request valid
//   i_imem_req_ready  memory accepts request
//   o_imem_addr       word-aligned fetch address (0 when no request)
//   i_imem_rsp_valid  read data valid, in order, one per accepted request
//   i_imem_rsp_data   instruction word
//   i_pc_src          redirect strobe
//   i_pc_target       redirect address (bits [1:0] ignored)
//   o_instr_valid     FIFO head valid
//   i_instr_ready     downstream consumes head
//   o_instr           head instruction word (0 when empty)
//   o_pc              head instruction address (0 when empty)
//   o_op              o_instr[6:0]
//   o_funct3          o_instr[14:12]
//   o_funct7          o_instr[30]
// ---------------------------------------------------------------------------
module block_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_imem_req_valid,
    input  logic            i_imem_req_ready,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_rsp_valid,
    input  logic [XLEN-1:0] i_imem_rsp_data,
    input  logic            i_pc_src,
    input  logic [XLEN-1:0] i_pc_target,
    output logic            o_instr_valid,
    input  logic            i_instr_ready,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [6:0]      o_op,
    output logic [2:0]      o_funct3,
    output logic            o_funct7
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t          state_r;
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] req_pc_r;
    logic            drop_r;
    logic [XLEN-1:0] data_r [DEPTH];
    logic [XLEN-1:0] pc_r   [DEPTH];
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW:0]     count_r;

    logic            req_valid_s;
    logic            handshake_s;
    logic            push_s;
    logic            pop_s;
    logic            head_valid_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] head_instr_s;
    logic [XLEN-1:0] head_pc_s;

    // At most one request is ever outstanding (only in WAIT), so the credit
    // check in REQ reduces to the FIFO occupancy alone.
    assign req_valid_s  = (state_r == ST_REQ) && (count_r < DEPTH_CNT);
    assign handshake_s  = req_valid_s && i_imem_req_ready;
    assign head_valid_s = (count_r != {(AW+1){1'b0}});
    assign target_s     = i_pc_target & ~{{(XLEN-2){1'b0}}, 2'b11};
    // A redirect flushes the FIFO, so neither a push nor a pop survives it.
    assign push_s       = (state_r == ST_WAIT) && i_imem_rsp_valid && !drop_r && !i_pc_src;
    assign pop_s        = head_valid_s && i_instr_ready && !i_pc_src;

    // Fetch FSM, PC, drop flag and instruction FIFO state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= {XLEN{1'b0}};
            drop_r     <= 1'b0;
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= {XLEN{1'b0}};
                pc_r[i]   <= {XLEN{1'b0}};
            end
        end else if (i_pc_src) begin
            fetch_pc_r <= target_s;
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            case (state_r)
                ST_REQ: begin
                    // A request accepted this cycle is already stale.
                    if (handshake_s) begin
                        state_r <= ST_WAIT;
                        drop_r  <= 1'b1;
                    end else begin
                        state_r <= ST_REQ;
                        drop_r  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // A response landing with the redirect is simply not pushed.
                    if (i_imem_rsp_valid) begin
                        state_r <= ST_REQ;
                        drop_r  <= 1'b0;
                    end else begin
                        state_r <= ST_WAIT;
                        drop_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_REQ;
                    drop_r  <= 1'b0;
                end
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_REQ;
                end
                ST_REQ: begin
                    if (handshake_s) begin
                        state_r    <= ST_WAIT;
                        req_pc_r   <= fetch_pc_r;
                        fetch_pc_r <= fetch_pc_r + XLEN'(4);
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (i_imem_rsp_valid) begin
                        state_r <= ST_REQ;
                        drop_r  <= 1'b0;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            if (push_s) begin
                data_r[wr_ptr_r] <= i_imem_rsp_data;
                pc_r[wr_ptr_r]   <= req_pc_r;
                wr_ptr_r         <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
        end
    end

    // Head entry selection; all head fields read as zero when the FIFO is empty.
    always_comb begin
        head_instr_s = {XLEN{1'b0}};
        head_pc_s    = {XLEN{1'b0}};
        if (head_valid_s) begin
            head_instr_s = data_r[rd_ptr_r];
            head_pc_s    = pc_r[rd_ptr_r];
        end else begin
            head_instr_s = {XLEN{1'b0}};
            head_pc_s    = {XLEN{1'b0}};
        end
    end

    assign o_imem_req_valid = req_valid_s;
    assign o_imem_addr      = req_valid_s ? fetch_pc_r : {XLEN{1'b0}};
    assign o_instr_valid    = head_valid_s;
    assign o_instr          = head_instr_s;
    assign o_pc             = head_pc_s;
    assign o_op             = head_instr_s[6:0];
    assign o_funct3         = head_instr_s[14:12];
    assign o_funct7         = head_instr_s[30];

endmodule

// File: tb/tb_block_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_block_fetch_unit
// Drives block_fetch_unit against a small instruction-memory model with a
// programmable response latency. Consumed instructions are checked against a
// queue of expected PCs; each scenario task also checks request traffic and
// head fields directly.
// ---------------------------------------------------------------------------
module tb_block_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        instr_ready;
    logic        o_imem_req_valid;
    logic [31:0] o_imem_addr;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [6:0]  o_op;
    logic [2:0]  o_funct3;
    logic        o_funct7;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    int          req_count    = 0;
    int          mem_lat      = 0;
    logic [31:0] req_log   [$];
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [31:0] exp_q     [$];

    // 100 MHz-style free running clock.
    always #5 clk = ~clk;

    block_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (imem_req_ready),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rsp_valid (imem_rsp_valid),
        .i_imem_rsp_data  (imem_rsp_data),
        .i_pc_src         (pc_src),
        .i_pc_target      (pc_target),
        .o_instr_valid    (o_instr_valid),
        .i_instr_ready    (instr_ready),
        .o_instr          (o_instr),
        .o_pc             (o_pc),
        .o_op             (o_op),
        .o_funct3         (o_funct3),
        .o_funct7         (o_funct7)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0033;
            32'h0000_0004: return 32'h0041_0113;
            default:       return {a[15:0], a[15:0]} ^ 32'h4000_70B3;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: log handshakes, answer each after 1+mem_lat cycles.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && o_imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
                req_count++;
                req_log.push_back(o_imem_addr);
                pend_addr.push_back(o_imem_addr);
                pend_due.push_back(cyc + 1 + mem_lat);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end
        end
    end

    // Scoreboard: every consumed head must match the next expected PC.
    initial begin
        logic [31:0] epc;
        logic [31:0] ew;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && o_instr_valid === 1'b1 && instr_ready === 1'b1 && pc_src === 1'b0) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected: consumed pc=%h, required no consumption", o_pc);
                end else begin
                    epc = exp_q.pop_front();
                    ew  = mem_word(epc);
                    if (o_pc !== epc || o_instr !== ew) begin
                        tests_failed++;
                        $display("FAIL sb_word: got pc=%h instr=%h, required pc=%h instr=%h", o_pc, o_instr, epc, ew);
                    end
                    tests_run++;
                    if ({o_op, o_funct3, o_funct7} !== {ew[6:0], ew[14:12], ew[30]}) begin
                        tests_failed++;
                        $display("FAIL sb_fields: got op=%b f3=%b f7=%b, required op=%b f3=%b f7=%b",
                                 o_op, o_funct3, o_funct7, ew[6:0], ew[14:12], ew[30]);
                    end
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (o_instr_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tests_run++;
        if (o_instr_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL drain_timeout: o_instr_valid=%b, required 1", o_instr_valid);
        end else begin
            instr_ready = 1'b1;
            tick();
            instr_ready = 1'b0;
        end
    endtask

    task automatic wait_req(input int target);
        int n = 0;
        while (req_count < target && n < 30) begin
            tick();
            n++;
        end
        tests_run++;
        if (req_count < target) begin
            tests_failed++;
            $display("FAIL req_timeout: req_count=%0d, required %0d", req_count, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        tests_run++;
        if ({o_imem_req_valid, o_instr_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_valids: req_valid=%b instr_valid=%b, required 0 0", o_imem_req_valid, o_instr_valid);
        end
        tests_run++;
        if ({o_imem_addr, o_instr, o_pc, o_op, o_funct3, o_funct7} !== 107'h0) begin
            tests_failed++;
            $display("FAIL reset_data: addr=%h instr=%h pc=%h op=%b f3=%b f7=%b, required all 0",
                     o_imem_addr, o_instr, o_pc, o_op, o_funct3, o_funct7);
        end
        req_count = 0;
        req_log.delete();
    endtask

    task automatic test_fetch_fill();
        logic [63:0] got;
        rst_n = 1'b1;
        repeat (10) tick();
        tests_run++;
        if (req_count !== 2) begin
            tests_failed++;
            $display("FAIL fill_req_count: got %0d, required 2", req_count);
        end
        got = (req_log.size() >= 2) ? {req_log[0], req_log[1]} : 64'hFFFF_FFFF_FFFF_FFFF;
        tests_run++;
        if (got !== 64'h0000_0000_0000_0004) begin
            tests_failed++;
            $display("FAIL fill_req_addrs: got %h, required 00000000_00000004", got);
        end
        tests_run++;
        if (o_imem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_req_stop: req_valid=%b, required 0", o_imem_req_valid);
        end
        tests_run++;
        if ({o_instr_valid, o_pc, o_op, o_funct3, o_funct7} !== {1'b1, 32'h0, 7'b0110011, 3'b000, 1'b0}) begin
            tests_failed++;
            $display("FAIL fill_head0: valid=%b pc=%h op=%b f3=%b f7=%b, required 1 0 0110011 000 0",
                     o_instr_valid, o_pc, o_op, o_funct3, o_funct7);
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
    endtask

    task automatic test_req_stall();
        imem_req_ready = 1'b0;
        drain();
        tests_run++;
        if ({o_pc, o_op, o_funct3} !== {32'h4, 7'b0010011, 3'b000}) begin
            tests_failed++;
            $display("FAIL stall_head1: pc=%h op=%b f3=%b, required 4 0010011 000", o_pc, o_op, o_funct3);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) imem_req_ready = 1'b1;
            tests_run++;
            if ({o_imem_req_valid, o_imem_addr} !== {1'b1, 32'h8}) begin
                tests_failed++;
                $display("FAIL stall_hold_c%0d: valid=%b addr=%h, required 1 8", i, o_imem_req_valid, o_imem_addr);
            end
            tick();
        end
        tests_run++;
        if (req_count !== 3 || req_log[req_log.size()-1] !== 32'h8) begin
            tests_failed++;
            $display("FAIL stall_handshake: count=%0d last=%h, required 3 8", req_count, req_log[req_log.size()-1]);
        end
        repeat (4) tick();
        tests_run++;
        if (req_count !== 3) begin
            tests_failed++;
            $display("FAIL stall_single: count=%0d, required 3", req_count);
        end
        drain();
    endtask

    task automatic test_redirect_wait();
        mem_lat = 2;
        wait_req(4);
        tests_run++;
        if ({req_log[req_log.size()-1], o_instr_valid, o_pc} !== {32'hC, 1'b1, 32'h8}) begin
            tests_failed++;
            $display("FAIL rdw_setup: last_req=%h valid=%b pc=%h, required c 1 8",
                     req_log[req_log.size()-1], o_instr_valid, o_pc);
        end
        pc_src    = 1'b1;
        pc_target = 32'h0000_0103;
        tick();
        pc_src = 1'b0;
        tests_run++;
        if ({o_instr_valid, o_imem_req_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rdw_flush: instr_valid=%b req_valid=%b, required 0 0", o_instr_valid, o_imem_req_valid);
        end
        wait_req(5);
        tests_run++;
        if (req_log[req_log.size()-1] !== 32'h100) begin
            tests_failed++;
            $display("FAIL rdw_target: addr=%h, required 100", req_log[req_log.size()-1]);
        end
        mem_lat = 0;
        exp_q.push_back(32'h100);
        drain();
        repeat (10) tick();
    endtask

    task automatic test_redirect_same_cycle();
        int rc;
        int n;
        imem_req_ready = 1'b0;
        tests_run++;
        if ({o_imem_req_valid, o_instr_valid} !== 2'b01) begin
            tests_failed++;
            $display("FAIL rds_full: req_valid=%b instr_valid=%b, required 0 1", o_imem_req_valid, o_instr_valid);
        end
        // Redirect in REQ with no handshake.
        pc_src    = 1'b1;
        pc_target = 32'h0000_0300;
        tick();
        pc_src = 1'b0;
        tests_run++;
        if ({o_instr_valid, o_imem_req_valid, o_imem_addr} !== {1'b0, 1'b1, 32'h300}) begin
            tests_failed++;
            $display("FAIL rds_req_redirect: instr_valid=%b req_valid=%b addr=%h, required 0 1 300",
                     o_instr_valid, o_imem_req_valid, o_imem_addr);
        end
        // Redirect together with a request handshake.
        rc             = req_count;
        imem_req_ready = 1'b1;
        pc_src         = 1'b1;
        pc_target      = 32'h0000_0402;
        tick();
        pc_src = 1'b0;
        tests_run++;
        if ({req_count == rc + 1, req_log[req_log.size()-1], o_imem_req_valid} !== {1'b1, 32'h300, 1'b0}) begin
            tests_failed++;
            $display("FAIL rds_hs_redirect: new_reqs=%0d last=%h req_valid=%b, required 1 300 0",
                     req_count - rc, req_log[req_log.size()-1], o_imem_req_valid);
        end
        wait_req(rc + 2);
        tests_run++;
        if (req_log[req_log.size()-1] !== 32'h400) begin
            tests_failed++;
            $display("FAIL rds_hs_target: addr=%h, required 400", req_log[req_log.size()-1]);
        end
        exp_q.push_back(32'h400);
        drain();
        // Redirect together with a response.
        n = 0;
        tick();
        #1;
        while (imem_rsp_valid !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        tests_run++;
        if (imem_rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rds_rsp_timeout: rsp_valid=%b, required 1", imem_rsp_valid);
        end
        pc_src    = 1'b1;
        pc_target = 32'h0000_0500;
        tick();
        pc_src = 1'b0;
        tests_run++;
        if ({o_instr_valid, o_imem_req_valid, o_imem_addr} !== {1'b0, 1'b1, 32'h500}) begin
            tests_failed++;
            $display("FAIL rds_rsp_redirect: instr_valid=%b req_valid=%b addr=%h, required 0 1 500",
                     o_instr_valid, o_imem_req_valid, o_imem_addr);
        end
        exp_q.push_back(32'h500);
        drain();
    endtask

    task automatic test_reset_during_wait();
        int  rc;
        int  n = 0;
        logic found;
        mem_lat   = 3;
        pc_src    = 1'b1;
        pc_target = 32'h0000_0600;
        tick();
        pc_src = 1'b0;
        found  = (req_log.size() > 0) && (req_log[req_log.size()-1] === 32'h600);
        while (!found && n < 30) begin
            tick();
            n++;
            found = (req_log.size() > 0) && (req_log[req_log.size()-1] === 32'h600);
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL rst_wait_setup: last_req=%h, required 600", req_log[req_log.size()-1]);
        end
        rst_n   = 1'b0;
        mem_lat = 0;
        tick();
        tests_run++;
        if ({o_imem_req_valid, o_instr_valid, o_imem_addr, o_instr, o_pc, o_op, o_funct3, o_funct7} !== 109'h0) begin
            tests_failed++;
            $display("FAIL rst_wait_outputs: req_valid=%b instr_valid=%b addr=%h instr=%h pc=%h, required all 0",
                     o_imem_req_valid, o_instr_valid, o_imem_addr, o_instr, o_pc);
        end
        rst_n          = 1'b1;
        imem_req_ready = 1'b0;
        repeat (3) tick();
        tests_run++;
        if ({o_instr_valid, o_imem_req_valid, o_imem_addr} !== {1'b0, 1'b1, 32'h0}) begin
            tests_failed++;
            $display("FAIL rst_wait_stale: instr_valid=%b req_valid=%b addr=%h, required 0 1 0",
                     o_instr_valid, o_imem_req_valid, o_imem_addr);
        end
        rc             = req_count;
        imem_req_ready = 1'b1;
        wait_req(rc + 1);
        tests_run++;
        if (req_log[req_log.size()-1] !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_wait_first: addr=%h, required 0", req_log[req_log.size()-1]);
        end
        exp_q.push_back(32'h0);
        drain();
    endtask

    // Scenario sequence and summary.
    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        pc_src         = 1'b0;
        pc_target      = 32'h0;
        instr_ready    = 1'b0;
        test_reset();
        test_fetch_fill();
        test_req_stall();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_reset_during_wait();
        repeat (3) tick();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_leftover: %0d expected instructions not consumed, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
